// File: rtl/instr_mem_pkg.sv
// Shared constants, the built-in boot program and byte-address decode helpers
// for the CPU instruction memory.
package instr_mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam logic [DATA_W-1:0] NOP = 16'h0000;

  localparam int unsigned DEFAULT_PROGRAM_LEN = 8;

  // Encodings are owned by the CPU team; treat as opaque words here.
  localparam logic [DATA_W-1:0] DEFAULT_PROGRAM [DEFAULT_PROGRAM_LEN] = '{
    16'h1101, 16'h1202, 16'h3312, 16'h4403,
    16'h5504, 16'h6000, 16'h7E05, 16'hF000
  };

  typedef struct packed {
    logic [31:0] index;
    logic        in_range;
    logic        odd;
  } addr_dec_t;

  // Split a byte address into a word index and an in-range flag for a memory
  // of 2**idx_w words.
  function automatic addr_dec_t decode_addr(input logic [31:0] addr, input int unsigned idx_w);
    addr_dec_t d;
    d.index    = (addr >> 1) & ((32'd1 << idx_w) - 32'd1);
    d.in_range = (addr >> (idx_w + 1)) == 32'd0;
    d.odd      = addr[0];
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] image_word(input int unsigned i);
    logic [DATA_W-1:0] w;
    w = NOP;
    for (int unsigned j = 0; j < DEFAULT_PROGRAM_LEN; j++) begin
      if (j == i) w = DEFAULT_PROGRAM[j];
    end
    return w;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Word-organised instruction memory: combinational byte-addressed fetch port,
// synchronous load port, asynchronous reload of the default program image.
module instr_mem #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = instr_mem_pkg::DATA_W,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic              addr_fault,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);
  import instr_mem_pkg::*;

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_word;
  addr_dec_t         rd_dec;
  addr_dec_t         wr_dec;
  logic              unused_wr_odd;

  assign rd_dec        = decode_addr(32'(pc), IdxW);
  assign wr_dec        = decode_addr(32'(waddr), IdxW);
  assign unused_wr_odd = wr_dec.odd;

  // Odd in-range addresses still return the aligned word; only the fault flags it.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_dec.index == i) rd_word = mem_q[i];
    end
    instruction = rd_dec.in_range ? rd_word : DATA_W'(NOP);
    addr_fault  = rd_dec.odd | ~rd_dec.in_range;
  end

  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (we && wr_dec.in_range && (wr_dec.index == i)) mem_d[i] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(image_word(i));
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_instr_mem;
  import instr_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        addr_fault;
  logic        we;
  logic [15:0] waddr;
  logic [15:0] wdata;

  int checks;
  int failures;
  bit cmp_en;

  logic [15:0] model [64];

  instr_mem #(
    .DEPTH (64),
    .DATA_W(16),
    .ADDR_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .instruction(instruction),
    .addr_fault (addr_fault),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [15:0] ref_image(input int i);
    logic [15:0] w;
    w = 16'h0000;
    for (int j = 0; j < int'(DEFAULT_PROGRAM_LEN); j++) begin
      if (j == i) w = DEFAULT_PROGRAM[j];
    end
    return w;
  endfunction

  function automatic logic [15:0] exp_instr(input logic [15:0] a);
    if (a < 16'h0080) return model[a[6:1]];
    return 16'h0000;
  endfunction

  function automatic logic exp_fault(input logic [15:0] a);
    return a[0] || (a >= 16'h0080);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h (pc=%h)", name, $time, act, req, pc);
    end
  endtask

  // Reference model: reset reloads the image, a write lands only when in range.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) model[i] = ref_image(i);
    end else if (we && (waddr < 16'h0080)) begin
      model[waddr[6:1]] = wdata;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cycle_instr", instruction, exp_instr(pc));
      chk("cycle_fault", {15'd0, addr_fault}, {15'd0, exp_fault(pc)});
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #5;
    we    = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #5;
    we = 1'b0;
  endtask

  task automatic probe(input string name, input logic [15:0] a, input logic [15:0] req_i,
                       input logic req_f);
    pc = a;
    #1;
    chk(name, instruction, req_i);
    chk({name, "_fault"}, {15'd0, addr_fault}, {15'd0, req_f});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b1;
    pc       = '0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    for (int i = 0; i < 64; i++) model[i] = ref_image(i);

    #1 rst_n = 1'b0;
    @(posedge clk);
    #5 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Reset image sweep
    for (int i = 0; i < 'h32; i++) begin
      @(posedge clk);
      #5;
      probe("sweep", 16'(2 * i), ref_image(i), 1'b0);
    end
    @(posedge clk);
    #5 probe("pin_word0", 16'h0000, 16'h1101, 1'b0);
    #1 probe("pin_word7", 16'h000E, 16'hF000, 1'b0);
    #1 probe("pin_word8", 16'h0010, 16'h0000, 1'b0);

    // Write/readback
    wr(16'h0010, 16'hA5C3);
    wr(16'h007E, 16'h1234);
    probe("wr_0010", 16'h0010, 16'hA5C3, 1'b0);
    #1 probe("wr_007e", 16'h007E, 16'h1234, 1'b0);
    #1 probe("wr_0010_again", 16'h0010, 16'hA5C3, 1'b0);

    // Write edge timing
    @(posedge clk);
    #5;
    pc    = 16'h0020;
    we    = 1'b1;
    waddr = 16'h0020;
    wdata = 16'hBEEF;
    #1 chk("edge_before", instruction, 16'h0000);
    @(posedge clk);
    #1 chk("edge_after", instruction, 16'hBEEF);
    #4 we = 1'b0;

    // Out-of-range and misaligned
    @(posedge clk);
    #5 probe("oor_0080", 16'h0080, 16'h0000, 1'b1);
    #1 probe("odd_0011", 16'h0011, 16'hA5C3, 1'b1);
    #1 probe("oor_ffff", 16'hFFFF, 16'h0000, 1'b1);
    wr(16'h0080, 16'hDEAD);
    probe("oorwr_0000", 16'h0000, 16'h1101, 1'b0);
    #1 probe("oorwr_007e", 16'h007E, 16'h1234, 1'b0);

    // Reset mid-operation, with a write pending
    @(posedge clk);
    #5;
    pc    = 16'h0020;
    we    = 1'b1;
    waddr = 16'h0020;
    wdata = 16'h5555;
    #2 rst_n = 1'b0;
    #1 chk("rst_async_0020", instruction, 16'h0000);
    probe("rst_async_007e", 16'h007E, 16'h0000, 1'b0);
    pc = 16'h0020;
    @(posedge clk);
    #5 rst_n = 1'b1;
    #1 chk("rst_no_write", instruction, 16'h0000);
    @(posedge clk);
    #1 chk("first_write_after_release", instruction, 16'h5555);
    #4 we = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #5;
      pc    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h00FF));
      we    = ($urandom_range(0, 2) == 0);
      waddr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h00FF));
      wdata = 16'($urandom);
    end
    @(posedge clk);
    #5 we = 1'b0;
    @(posedge clk);
    #5 cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
